snake_game_ctrl: RTL and testbench

Game-state sequencer for the Crazy Snake VGA design. Paces snake movement with a tick divider and commits each move only at the start of vertical blanking, so the renderer never sees a half-updated frame. Applies button direction with reversal protection, detects wall collision and food capture, relocates food from the random generator, and keeps the score. Outputs feed the VGA graphics unit as registered grid coordinates.

---
 rtl/snake_game_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-state sequencer for the Crazy Snake VGA design.
// A free-running divider paces the snake. Each move is committed only at the
// start of vertical blanking, so the renderer never sees a half-updated frame.
// Pulse contract: frame_start is a one-cycle strobe with no back-pressure. It
// is acted on only while a tick is pending (WAIT_VB), and is otherwise ignored.
// upd is a one-cycle strobe raised once the head, score and food registers
// all hold the new move's values.
module snake_game_ctrl #(
  parameter int TICK_DIV = 6250000,
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [1:0] move_dir,
  input  logic [7:0] rand_x,
  input  logic [7:0] rand_y,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [5:0] food_x,
  output logic [5:0] food_y,
  output logic [7:0] score,
  output logic       game_over,
  output logic       upd,
  output logic [2:0] fsm_state
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [5:0] LAST_X = 6'(GRID_W - 1);
  localparam logic [5:0] LAST_Y = 6'(GRID_H - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_WAIT_VB = 3'd1,
    S_MOVE    = 3'd2,
    S_CHECK   = 3'd3,
    S_FOOD    = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       dir_req;
  logic [1:0]       cur_dir, cur_dir_d;
  logic [5:0]       head_x_d, head_y_d, food_x_d, food_y_d;
  logic [7:0]       score_d;
  logic             game_over_d, upd_d;

  // Move datapath results
  logic             reverse;
  logic [1:0]       app_dir;
  logic [5:0]       nxt_x, nxt_y;
  logic             hit_wall;
  logic [5:0]       cand_x, cand_y;
  logic             cand_on_head;

  // Upper random bits are deliberately not used for placement.
  logic unused_rand_bits;
  assign unused_rand_bits = ^{rand_x[7:6], rand_y[7:6]};

  assign tick      = (tick_cnt == TICK_LAST);
  assign fsm_state = state_q;

  // Free-running movement divider, wraps after TICK_DIV cycles
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Button direction is sampled every cycle; only MOVE consumes it
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      dir_req <= DIR_RIGHT;
    end else begin
      dir_req <= move_dir;
    end
  end

  // Applied direction (reversal blocked), next head cell and wall detection
  always_comb begin
    reverse  = (dir_req[1] == cur_dir[1]) && (dir_req[0] != cur_dir[0]);
    app_dir  = reverse ? cur_dir : dir_req;
    nxt_x    = head_x;
    nxt_y    = head_y;
    hit_wall = 1'b0;
    case (app_dir)
      DIR_UP: begin
        if (head_y == 6'd0) hit_wall = 1'b1;
        else                nxt_y    = head_y - 6'd1;
      end
      DIR_DOWN: begin
        if (head_y == LAST_Y) hit_wall = 1'b1;
        else                  nxt_y    = head_y + 6'd1;
      end
      DIR_LEFT: begin
        if (head_x == 6'd0) hit_wall = 1'b1;
        else                nxt_x    = head_x - 6'd1;
      end
      default: begin
        if (head_x == LAST_X) hit_wall = 1'b1;
        else                  nxt_x    = head_x + 6'd1;
      end
    endcase
  end

  // Food candidate folded into the grid by a single subtraction
  always_comb begin
    cand_x = rand_x[5:0];
    cand_y = rand_y[5:0];
    if ({1'b0, rand_x[5:0]} >= 7'(GRID_W)) cand_x = rand_x[5:0] - 6'(GRID_W);
    if ({1'b0, rand_y[5:0]} >= 7'(GRID_H)) cand_y = rand_y[5:0] - 6'(GRID_H);
    cand_on_head = (cand_x == head_x) && (cand_y == head_y);
  end

  // Next-state and next-value logic for the game sequencer
  always_comb begin
    state_d     = state_q;
    head_x_d    = head_x;
    head_y_d    = head_y;
    food_x_d    = food_x;
    food_y_d    = food_y;
    score_d     = score;
    cur_dir_d   = cur_dir;
    game_over_d = game_over;
    upd_d       = 1'b0;
    case (state_q)
      S_RUN: begin
        if (tick) state_d = S_WAIT_VB;
      end
      S_WAIT_VB: begin
        if (frame_start) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (hit_wall) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          head_x_d  = nxt_x;
          head_y_d  = nxt_y;
          cur_dir_d = app_dir;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((head_x == food_x) && (head_y == food_y)) begin
          if (score != 8'hFF) score_d = score + 8'd1;
          state_d = S_FOOD;
        end else begin
          upd_d   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_FOOD: begin
        if (!cand_on_head) begin
          food_x_d = cand_x;
          food_y_d = cand_y;
          upd_d    = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Game-state registers; reset discards any partially processed move
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_RUN;
      head_x    <= 6'd32;
      head_y    <= 6'd24;
      food_x    <= 6'd48;
      food_y    <= 6'd24;
      score     <= 8'd0;
      cur_dir   <= DIR_RIGHT;
      game_over <= 1'b0;
      upd       <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_x    <= head_x_d;
      head_y    <= head_y_d;
      food_x    <= food_x_d;
      food_y    <= food_y_d;
      score     <= score_d;
      cur_dir   <= cur_dir_d;
      game_over <= game_over_d;
      upd       <= upd_d;
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus a randomized walk, checked
// against a cell-level game model (position, heading, food, score, over flag).
module tb_snake_game_ctrl;

  localparam int TICK_DIV = 4;
  localparam int GRID_W   = 64;
  localparam int GRID_H   = 48;

  logic       board_clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic [1:0] move_dir;
  logic [7:0] rand_x, rand_y;
  logic [5:0] head_x, head_y, food_x, food_y;
  logic [7:0] score;
  logic       game_over, upd;
  logic [2:0] fsm_state;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";
  int    cyc;

  // Game model
  int         m_hx, m_hy, m_fx, m_fy, m_score, m_over;
  logic [1:0] m_dir;
  int         opp [4] = '{1, 0, 3, 2};
  int         dx  [4] = '{0, 0, -1, 1};
  int         dy  [4] = '{-1, 1, 0, 0};
  logic [11:0] exp_q[$];

  snake_game_ctrl #(.TICK_DIV(TICK_DIV), .GRID_W(GRID_W), .GRID_H(GRID_H)) dut (
    .board_clk  (board_clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .move_dir   (move_dir),
    .rand_x     (rand_x),
    .rand_y     (rand_y),
    .head_x     (head_x),
    .head_y     (head_y),
    .food_x     (food_x),
    .food_y     (food_y),
    .score      (score),
    .game_over  (game_over),
    .upd        (upd),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle count since reset release (tick every TICK_DIV cycles)
  always #5 board_clk = ~board_clk;

  always @(posedge board_clk or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s %s: observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  function automatic int wrapc(input logic [7:0] v, input int n);
    int c;
    c = int'(v[5:0]);
    if (c >= n) c = c - n;
    return c;
  endfunction

  task automatic model_reset();
    m_hx = 32; m_hy = 24; m_fx = 48; m_fy = 24;
    m_score = 0; m_over = 0; m_dir = 2'b11;
    exp_q.delete();
  endtask

  task automatic check_all();
    chk("head_x", head_x, m_hx);
    chk("head_y", head_y, m_hy);
    chk("food_x", food_x, m_fx);
    chk("food_y", food_y, m_fy);
    chk("score", score, m_score);
    chk("game_over", game_over, m_over);
  endtask

  // Reset pulse; outputs must return to reset values while Reset is high
  task automatic do_reset(input bit check_it);
    @(negedge board_clk);
    Reset = 1'b1;
    frame_start = 1'b0;
    #1;
    model_reset();
    if (check_it) begin
      check_all();
      chk("upd_in_reset", upd, 0);
    end
    @(negedge board_clk);
    @(negedge board_clk);
    Reset = 1'b0;
  endtask

  // Wait for the negedge inside a tick cycle
  task automatic align_tick();
    @(negedge board_clk);
    while ((cyc % TICK_DIV) != TICK_DIV - 1) @(negedge board_clk);
  endtask

  // One move: frame_start two cycles after a tick, then timed checks.
  // retries = number of FOOD cycles the random source points at the head.
  task automatic do_move(input logic [1:0] d, input int retries,
                         input logic [7:0] rx, input logic [7:0] ry);
    logic [1:0] app;
    int nx, ny, wall, eat, exp_score;
    logic [7:0] bx, by;
    app  = (int'(d) == opp[m_dir]) ? m_dir : d;
    nx   = m_hx + dx[app];
    ny   = m_hy + dy[app];
    wall = (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) ? 1 : 0;
    eat  = (!wall && nx == m_fx && ny == m_fy) ? 1 : 0;
    while (eat != 0 && wrapc(rx, GRID_W) == nx && wrapc(ry, GRID_H) == ny)
      rx = 8'($urandom_range(0, 255));
    bx = {2'($urandom_range(0, 3)), 6'(nx)};
    by = (ny < 16) ? 8'(ny + GRID_H) : 8'(ny);
    exp_score = (eat != 0 && m_score < 255) ? m_score + 1 : m_score;
    if (wall != 0) begin
      m_over = 1;
    end else begin
      m_hx = nx; m_hy = ny; m_dir = app;
    end
    if (eat != 0) exp_q.push_back({6'(wrapc(rx, GRID_W)), 6'(wrapc(ry, GRID_H))});

    align_tick();
    repeat (2) @(negedge board_clk);
    move_dir = d;
    frame_start = 1'b1;
    rand_x = (retries > 0) ? bx : rx;
    rand_y = (retries > 0) ? by : ry;
    @(negedge board_clk);
    frame_start = 1'b0;
    @(negedge board_clk);
    chk("head_x", head_x, m_hx);
    chk("head_y", head_y, m_hy);
    chk("game_over", game_over, m_over);
    chk("upd_early", upd, 0);
    @(negedge board_clk);
    if (wall != 0) begin
      chk("upd_wall", upd, 0);
      chk("score_wall", score, m_score);
      return;
    end
    m_score = exp_score;
    chk("score", score, m_score);
    if (eat == 0) begin
      chk("upd", upd, 1);
      @(negedge board_clk);
      chk("upd_single", upd, 0);
      return;
    end
    chk("upd_eat", upd, 0);
    for (int i = 1; i <= retries; i++) begin
      @(negedge board_clk);
      chk("upd_retry", upd, 0);
      chk("food_hold", {food_x, food_y}, {6'(m_fx), 6'(m_fy)});
      if (i == retries) begin
        rand_x = rx;
        rand_y = ry;
      end
    end
    @(negedge board_clk);
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      m_fx = int'(e[11:6]);
      m_fy = int'(e[5:0]);
    end
    chk("food", {food_x, food_y}, {6'(m_fx), 6'(m_fy)});
    chk("upd_food", upd, 1);
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; move_dir = 2'b11;
    rand_x = 8'h00; rand_y = 8'h00;
    model_reset();

    // Reset state and idle without frame_start
    phase = "reset";
    do_reset(1'b1);
    phase = "idle";
    for (int i = 0; i < 20; i++) begin
      @(negedge board_clk);
      chk("upd_idle", upd, 0);
    end
    check_all();

    // frame_start coincident with tick in RUN is ignored
    phase = "coincident";
    do_reset(1'b0);
    align_tick();
    frame_start = 1'b1;
    @(negedge board_clk);
    frame_start = 1'b0;
    repeat (8) @(negedge board_clk);
    check_all();

    // Basic right move, then reversal request, then reach the food
    phase = "right";
    do_move(2'b11, 0, 8'h00, 8'h00);
    phase = "reversal";
    do_move(2'b10, 0, 8'h00, 8'h00);
    phase = "to_food";
    for (int i = 0; i < 13; i++) do_move(2'b11, 0, 8'($urandom), 8'($urandom));
    phase = "eat1";
    do_move(2'b11, 0, 8'h05, 8'h3A);
    chk("food_x_const", food_x, 5);
    chk("food_y_const", food_y, 10);

    // Turn up, walk to the new food, eat with the random source stuck on head
    phase = "up";
    do_move(2'b00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 13; i++) do_move(2'b00, 0, 8'($urandom), 8'($urandom));
    phase = "left";
    for (int i = 0; i < 42; i++) do_move(2'b10, 0, 8'($urandom), 8'($urandom));
    phase = "eat2_retry";
    do_move(2'b10, 3, 8'($urandom), 8'($urandom));

    // Randomized walk
    phase = "random";
    for (int i = 0; i < 30; i++) begin
      if (m_over != 0) break;
      do_move(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              8'($urandom), 8'($urandom));
    end

    // Reset while in FOOD discards the partial update
    phase = "reset_food";
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) do_move(2'b11, 0, 8'($urandom), 8'($urandom));
    align_tick();
    repeat (2) @(negedge board_clk);
    move_dir = 2'b11; frame_start = 1'b1;
    rand_x = 8'd48; rand_y = 8'd24;
    @(negedge board_clk);
    frame_start = 1'b0;
    @(negedge board_clk);
    chk("head_x_pre", head_x, 48);
    @(negedge board_clk);
    chk("score_pre", score, 1);
    @(negedge board_clk);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("upd_in_reset", upd, 0);
    @(negedge board_clk);
    Reset = 1'b0;
    phase = "after_food_reset";
    do_move(2'b11, 0, 8'h00, 8'h00);

    // Walk into the top wall, then OVER is frozen
    phase = "to_wall";
    for (int i = 0; i < 24; i++) do_move(2'b00, 0, 8'($urandom), 8'($urandom));
    chk("head_y_top", head_y, 0);
    phase = "wall";
    do_move(2'b00, 0, 8'h00, 8'h00);
    chk("game_over_wall", game_over, 1);
    phase = "frozen";
    for (int i = 0; i < 12; i++) begin
      @(negedge board_clk);
      frame_start = (i % 3 == 0);
      move_dir = 2'($urandom_range(0, 3));
      rand_x = 8'($urandom); rand_y = 8'($urandom);
      chk("upd_over", upd, 0);
    end
    frame_start = 1'b0;
    check_all();

    // Reset from OVER and resume
    phase = "reset_over";
    do_reset(1'b1);
    phase = "after_over_reset";
    do_move(2'b11, 0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
